// File: rtl/fft_input_frame_buffer_if.sv
// Handshake and frame bus between the sample source, the FFT input frame buffer
// and the stage-1 butterflies. The slave modport is the buffer's view.
interface fft_input_frame_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CNT_WIDTH = $clog2(DEPTH);

    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH-1:0]       D;
    logic                        frame_valid;
    logic                        frame_ack;
    logic [DEPTH*DATA_WIDTH-1:0] Q;
    logic [CNT_WIDTH-1:0]        fill_count;

    modport master (
        output in_valid, D, frame_ack,
        input  in_ready, frame_valid, Q, fill_count
    );

    modport slave (
        input  in_valid, D, frame_ack,
        output in_ready, frame_valid, Q, fill_count
    );
endinterface

// File: rtl/fft_input_frame_buffer.sv
// FFT input frame buffer: shifts accepted samples into a DEPTH-stage chain,
// counts them into frames and presents each full frame in parallel until it
// is acknowledged. Stage 0 holds the oldest sample of the frame.
// Optional macro FFT_IN_BITREV_EN: emit the frame lanes in bit-reversed order
// (DEPTH must then be a power of 2).
module fft_input_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    fft_input_frame_buffer_if.slave       bus
);
    localparam int CNT_WIDTH = $clog2(DEPTH);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  fill_reg, fill_next;
    logic [DATA_WIDTH-1:0] stage_reg [DEPTH];
    logic                  in_ready_int;
    logic                  accept;

    generate
        if (DEPTH < 2) begin : g_depth_check
            $error("fft_input_frame_buffer: DEPTH must be at least 2");
        end
    endgenerate

    // Ready: free while filling, only alongside an acknowledge once a frame is held.
    always_comb begin
        in_ready_int = 1'b0;
        if (!rst && !hold) begin
            in_ready_int = (state_reg == FILL) ? 1'b1 : bus.frame_ack;
        end
    end

    assign bus.in_ready = in_ready_int;
    assign accept       = bus.in_valid & in_ready_int;

    // Next state and fill counter; hold freezes everything.
    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        if (!hold) begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (fill_reg == CNT_WIDTH'(DEPTH - 1)) begin
                            fill_next  = '0;
                            state_next = FULL;
                        end else begin
                            fill_next = fill_reg + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.frame_ack) begin
                        state_next = FILL;
                        // A sample arriving with the ack starts the next frame.
                        fill_next  = bus.in_valid ? CNT_WIDTH'(1) : '0;
                    end
                end
                default: begin
                    state_next = FILL;
                    fill_next  = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
        end
    end

    // Shift chain: new samples enter at the top stage and move towards stage 0.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == DEPTH - 1) begin : g_top
                // Top stage loads the incoming sample.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else if (accept) begin
                        stage_reg[gi] <= bus.D;
                    end
                end
            end else begin : g_mid
                // Lower stages take the contents of the stage above.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg[gi] <= '0;
                    end else if (accept) begin
                        stage_reg[gi] <= stage_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

`ifdef FFT_IN_BITREV_EN
    function automatic int bitrev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            if (k[i]) r = r | (1 << (CNT_WIDTH - 1 - i));
        end
        return r;
    endfunction

    generate
        if ((DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_check
            $error("fft_input_frame_buffer: DEPTH must be a power of 2 for bit-reversed output");
        end
    endgenerate
`endif

    // Lane mapping is pure wiring from the stages.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
`ifdef FFT_IN_BITREV_EN
            localparam int SRC = bitrev(gi);
`else
            localparam int SRC = gi;
`endif
            assign bus.Q[gi*DATA_WIDTH +: DATA_WIDTH] = stage_reg[SRC];
        end
    endgenerate

    assign bus.frame_valid = (state_reg == FULL);
    assign bus.fill_count  = fill_reg;

endmodule

// File: tb/tb_fft_input_frame_buffer.sv
// Scoreboard bench for fft_input_frame_buffer: the driver applies directed and
// random beats, runs a queue-based frame model and pushes the expected response
// per cycle; a monitor pops and compares at each falling edge.
module tb_fft_input_frame_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst;
    logic hold;

    fft_input_frame_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fft_input_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  rdy;
        logic [CW-1:0]         fill;
        logic                  fv;
        logic                  chk_q;
        logic [DEPTH*DW-1:0]   q;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: partial frame as a queue (oldest first), a held frame, a full flag.
    logic [DW-1:0] part[$];
    logic [DW-1:0] frame[DEPTH];
    bit            mdl_full  = 1'b0;
    bit            zero_next = 1'b1;

    function automatic int lane_src(input int k);
`ifdef FFT_IN_BITREV_EN
        int r = 0;
        for (int i = 0; i < CW; i++) begin
            if (((k >> i) & 1) != 0) r = r + (1 << (CW - 1 - i));
        end
        return r;
`else
        return k;
`endif
    endfunction

    function automatic logic [DEPTH*DW-1:0] frame_word();
        logic [DEPTH*DW-1:0] w = '0;
        for (int k = 0; k < DEPTH; k++) w[k*DW +: DW] = frame[lane_src(k)];
        return w;
    endfunction

    // One beat: drive inputs, record expectations for this cycle, advance model.
    task automatic cycle(input bit r, input bit h, input bit v, input logic [DW-1:0] d, input bit a);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        hold          = h;
        bus.in_valid  = v;
        bus.D         = d;
        bus.frame_ack = a;
        e.rdy   = !r && !h && (!mdl_full || a);
        e.fill  = CW'(part.size());
        e.fv    = mdl_full;
        e.chk_q = mdl_full || zero_next;
        e.q     = zero_next ? '0 : frame_word();
        exp_q.push_back(e);
        if (r) begin
            part.delete();
            mdl_full  = 1'b0;
            zero_next = 1'b1;
        end else begin
            zero_next = 1'b0;
            if (e.rdy && mdl_full) mdl_full = 1'b0;
            if (v && e.rdy) begin
                part.push_back(d);
                if (part.size() == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) frame[k] = part[k];
                    part.delete();
                    mdl_full = 1'b1;
                end
            end
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.in_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL in_ready t=%0t got %b expected %b", $time, bus.in_ready, e.rdy);
                end
                checks++;
                if (bus.fill_count !== e.fill) begin
                    errors++;
                    $display("FAIL fill_count t=%0t got %0d expected %0d", $time, bus.fill_count, e.fill);
                end
                checks++;
                if (bus.frame_valid !== e.fv) begin
                    errors++;
                    $display("FAIL frame_valid t=%0t got %b expected %b", $time, bus.frame_valid, e.fv);
                end
                if (e.chk_q) begin
                    checks++;
                    if (bus.Q !== e.q) begin
                        errors++;
                        $display("FAIL Q t=%0t got %h expected %h", $time, bus.Q, e.q);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic.
    initial begin
        rst           = 1'b1;
        hold          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.D         = '0;
        bus.frame_ack = 1'b0;

        repeat (2) cycle(1, 0, 1, 32'hFFFF_FFFF, 0);
        for (int i = 1; i <= 8; i++) cycle(0, 0, 1, DW'(i), 0);
        repeat (3) cycle(0, 0, 1, 32'h55, 0);
        cycle(0, 0, 1, 32'd9, 1);
        for (int i = 10; i <= 16; i++) cycle(0, 0, 1, DW'(i), 0);
        cycle(0, 1, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 1);
        for (int i = 1; i <= 3; i++) cycle(0, 0, 1, DW'(i), 0);
        repeat (4) cycle(0, 1, 1, 32'hDEAD, 0);
        for (int i = 4; i <= 8; i++) cycle(0, 0, 1, DW'(i), 0);
        repeat (10) cycle(0, 0, 1, $urandom, 0);
        cycle(1, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0);

        for (int n = 0; n < 4000; n++) begin
            cycle(($urandom_range(299) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(3) != 0),
                  $urandom,
                  ($urandom_range(2) == 0));
        end
        cycle(0, 0, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
